pc_fetch: RTL

Program counter and instruction-fetch stage of the Little Computer CPU. It holds the 16-bit PC and presents it to instruction memory. It captures the returned instruction word and hands it to decode through a valid/ready handshake. It advances the PC with 16-bit increment semantics (0xFFFF wraps to 0x0000) and accepts jump redirects from execute. It sits directly upstream of the INC16 increment path, which computes the next sequential PC.

---
 rtl/pc_fetch.sv | 87 ++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: drives instruction memory from PC,
// captures the returned word and offers it to decode over a valid/ready handshake.
module pc_fetch #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_ADDR,
    output logic             IMEM_REQ,
    output logic [WIDTH-1:0] IMEM_ADDR,
    input  logic             IMEM_ACK,
    input  logic [WIDTH-1:0] IMEM_DATA,
    output logic             INSTR_VALID,
    input  logic             INSTR_READY,
    output logic [WIDTH-1:0] INSTR,
    output logic [WIDTH-1:0] INSTR_PC,
    output logic [WIDTH-1:0] PC
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;

    // Sequential increment; the carry out is dropped so the top address wraps to zero.
    function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] value);
        return value + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign IMEM_ADDR = PC;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= BOOT;
            PC          <= RESET_VECTOR;
            IMEM_REQ    <= 1'b0;
            INSTR_VALID <= 1'b0;
            INSTR       <= '0;
            INSTR_PC    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (LOAD) begin
                        PC <= LOAD_ADDR;
                    end
                    state    <= FETCH;
                    IMEM_REQ <= 1'b1;
                end
                FETCH: begin
                    // A redirect wins over a same-cycle acknowledge; that word is dropped.
                    if (LOAD) begin
                        PC <= LOAD_ADDR;
                    end else if (IMEM_ACK) begin
                        INSTR       <= IMEM_DATA;
                        INSTR_PC    <= PC;
                        PC          <= inc_wrap(PC);
                        INSTR_VALID <= 1'b1;
                        IMEM_REQ    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Either delivery or a flush ends the hold; INSTR/INSTR_PC keep their last word.
                    if (LOAD || INSTR_READY) begin
                        INSTR_VALID <= 1'b0;
                        IMEM_REQ    <= 1'b1;
                        state       <= FETCH;
                        if (LOAD) begin
                            PC <= LOAD_ADDR;
                        end
                    end
                end
                default: begin
                    state       <= BOOT;
                    IMEM_REQ    <= 1'b0;
                    INSTR_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
